// File: rtl/alu_exec_stage.sv
// Execute stage: operand select, ALU, SLT/SLTU and branch/jump resolution into one EX/MEM register.
// Latency 1 cycle. id_ready = !ex_valid || ex_ready, so a held entry stalls decode and flush kills everything.

package rvcpu;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;
endpackage

module alu #(
    parameter int Width = 32
) (
    input  rvcpu::alu_op_t    op_i,
    input  logic [Width-1:0]  a_i,
    input  logic [Width-1:0]  b_i,
    output logic [Width-1:0]  res_o,
    output logic [Width-1:0]  sum_o
);
    localparam int ShW = $clog2(Width);

    logic [ShW-1:0] shamt;

    assign shamt = b_i[ShW-1:0];
    // The plain sum is always exported so jump targets do not depend on the op field.
    assign sum_o = a_i + b_i;

    always_comb begin
        res_o = '0;
        case (op_i)
            rvcpu::ALU_ADD:  res_o = sum_o;
            rvcpu::ALU_SUB:  res_o = a_i - b_i;
            rvcpu::ALU_SLL:  res_o = a_i << shamt;
            rvcpu::ALU_SLT:  res_o = {{(Width-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            rvcpu::ALU_SLTU: res_o = {{(Width-1){1'b0}}, (a_i < b_i)};
            rvcpu::ALU_XOR:  res_o = a_i ^ b_i;
            rvcpu::ALU_SRL:  res_o = a_i >> shamt;
            rvcpu::ALU_SRA:  res_o = $signed(a_i) >>> shamt;
            rvcpu::ALU_OR:   res_o = a_i | b_i;
            rvcpu::ALU_AND:  res_o = a_i & b_i;
            default:         res_o = '0;
        endcase
    end
endmodule

module alu_exec_stage #(
    parameter int Width = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  rvcpu::alu_op_t    id_op,
    input  logic [Width-1:0]  id_pc,
    input  logic [Width-1:0]  id_rs1,
    input  logic [Width-1:0]  id_rs2,
    input  logic [Width-1:0]  id_imm,
    input  logic              id_a_pc,
    input  logic              id_b_imm,
    input  logic [1:0]        id_cmp,
    input  logic [2:0]        id_br,
    input  logic              id_is_br,
    input  logic              id_is_jmp,
    input  logic [4:0]        id_rd,
    input  logic              id_we,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [Width-1:0]  ex_result,
    output logic [4:0]        ex_rd,
    output logic              ex_we,
    output logic              redirect,
    output logic [Width-1:0]  redirect_pc
);
    logic [Width-1:0] op_a, op_b, alu_res, alu_sum, br_target;
    logic             eq, lt, ltu, br_cond, accept;

    logic             ex_valid_q, redirect_q, ex_we_q;
    logic [Width-1:0] ex_result_q, redirect_pc_q;
    logic [4:0]       ex_rd_q;

    logic [Width-1:0] ex_result_d, redirect_pc_d;
    logic             redirect_d, ex_we_d;

    assign op_a = id_a_pc  ? id_pc  : id_rs1;
    assign op_b = id_b_imm ? id_imm : id_rs2;

    alu #(.Width(Width)) u_alu (
        .op_i  (id_op),
        .a_i   (op_a),
        .b_i   (op_b),
        .res_o (alu_res),
        .sum_o (alu_sum)
    );

    // Compares always use the raw register operands, independent of operand muxing.
    assign eq  = (id_rs1 == id_rs2);
    assign lt  = ($signed(id_rs1) < $signed(id_rs2));
    assign ltu = (id_rs1 < id_rs2);

    always_comb begin
        br_cond = 1'b0;
        case (id_br)
            3'b000:  br_cond = eq;
            3'b001:  br_cond = !eq;
            3'b100:  br_cond = lt;
            3'b101:  br_cond = !lt;
            3'b110:  br_cond = ltu;
            3'b111:  br_cond = !ltu;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        ex_result_d = alu_res;
        case (id_cmp)
            2'b01:   ex_result_d = {{(Width-1){1'b0}}, lt};
            2'b10:   ex_result_d = {{(Width-1){1'b0}}, ltu};
            default: ex_result_d = id_is_jmp ? (id_pc + Width'(4)) : alu_res;
        endcase
    end

    assign br_target     = id_pc + id_imm;
    assign redirect_pc_d = id_is_jmp ? {alu_sum[Width-1:1], 1'b0} : br_target;
    assign redirect_d    = id_is_jmp || (id_is_br && br_cond);
    assign ex_we_d       = id_we && (id_rd != 5'd0);

    assign id_ready = !ex_valid_q || ex_ready;
    assign accept   = id_valid && id_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            redirect_q    <= 1'b0;
            ex_result_q   <= '0;
            redirect_pc_q <= '0;
            ex_rd_q       <= '0;
            ex_we_q       <= 1'b0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
            redirect_q <= 1'b0;
        end else if (accept) begin
            ex_valid_q    <= 1'b1;
            redirect_q    <= redirect_d;
            ex_result_q   <= ex_result_d;
            redirect_pc_q <= redirect_pc_d;
            ex_rd_q       <= id_rd;
            ex_we_q       <= ex_we_d;
        end else begin
            // Redirect is a single pulse; a held entry never re-fires it.
            redirect_q <= 1'b0;
            if (ex_valid_q && ex_ready) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_result   = ex_result_q;
    assign ex_rd       = ex_rd_q;
    assign ex_we       = ex_we_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized bench for alu_exec_stage against a transaction-level reference model.
module tb_alu_exec_stage;
    logic clk = 1'b0;
    logic rst, flush, id_valid, id_ready, id_a_pc, id_b_imm, id_is_br, id_is_jmp, id_we;
    rvcpu::alu_op_t id_op;
    logic [31:0] id_pc, id_rs1, id_rs2, id_imm, ex_result, redirect_pc;
    logic [1:0]  id_cmp;
    logic [2:0]  id_br;
    logic [4:0]  id_rd, ex_rd;
    logic        ex_valid, ex_ready, ex_we, redirect;

    always #5 clk = ~clk;

    alu_exec_stage #(.Width(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
        .id_a_pc(id_a_pc), .id_b_imm(id_b_imm), .id_cmp(id_cmp), .id_br(id_br),
        .id_is_br(id_is_br), .id_is_jmp(id_is_jmp), .id_rd(id_rd), .id_we(id_we),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_rd(ex_rd), .ex_we(ex_we), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    typedef struct {
        rvcpu::alu_op_t op;
        logic [31:0] pc, rs1, rs2, imm;
        logic a_pc, b_imm, is_br, is_jmp, we;
        logic [1:0] cmp;
        logic [2:0] br;
        logic [4:0] rd;
    } bundle_t;

    typedef struct {
        logic [31:0] result, target;
        logic [4:0]  rd;
        logic        we, taken;
    } exp_t;

    int n_vec = 0;
    int n_miss = 0;
    exp_t mq[$];
    exp_t cur_exp;
    logic exp_redir = 1'b0;
    logic [31:0] exp_rpc = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input bundle_t b);
        exp_t e;
        logic [31:0] a, x, alu_v;
        logic signed [31:0] sa, sx;
        logic lt, ltu, eq, cond;
        a  = b.a_pc  ? b.pc  : b.rs1;
        x  = b.b_imm ? b.imm : b.rs2;
        sa = a;
        sx = x;
        case (b.op)
            rvcpu::ALU_ADD:  alu_v = a + x;
            rvcpu::ALU_SUB:  alu_v = a - x;
            rvcpu::ALU_SLL:  alu_v = a << x[4:0];
            rvcpu::ALU_SLT:  alu_v = (sa < sx) ? 32'd1 : 32'd0;
            rvcpu::ALU_SLTU: alu_v = (a < x) ? 32'd1 : 32'd0;
            rvcpu::ALU_XOR:  alu_v = a ^ x;
            rvcpu::ALU_SRL:  alu_v = a >> x[4:0];
            rvcpu::ALU_SRA:  alu_v = sa >>> x[4:0];
            rvcpu::ALU_OR:   alu_v = a | x;
            default:         alu_v = a & x;
        endcase
        eq  = (b.rs1 == b.rs2);
        lt  = ($signed(b.rs1) < $signed(b.rs2));
        ltu = (b.rs1 < b.rs2);
        if (b.cmp == 2'd1)      e.result = {31'd0, lt};
        else if (b.cmp == 2'd2) e.result = {31'd0, ltu};
        else if (b.is_jmp)      e.result = b.pc + 32'd4;
        else                    e.result = alu_v;
        case (b.br)
            3'd0: cond = eq;
            3'd1: cond = !eq;
            3'd4: cond = lt;
            3'd5: cond = !lt;
            3'd6: cond = ltu;
            3'd7: cond = !ltu;
            default: cond = 1'b0;
        endcase
        e.taken  = b.is_jmp || (b.is_br && cond);
        e.target = b.is_jmp ? ((a + x) & 32'hFFFF_FFFE) : (b.pc + b.imm);
        e.rd     = b.rd;
        e.we     = b.we && (b.rd != 5'd0);
        return e;
    endfunction

    function automatic bundle_t nop();
        bundle_t b;
        b.op = rvcpu::ALU_ADD; b.pc = '0; b.rs1 = '0; b.rs2 = '0; b.imm = '0;
        b.a_pc = 0; b.b_imm = 0; b.is_br = 0; b.is_jmp = 0; b.we = 0;
        b.cmp = '0; b.br = 3'd2; b.rd = '0;
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        int kind;
        b.op     = rvcpu::alu_op_t'(4'($urandom_range(0, 9)));
        b.pc     = $urandom & 32'hFFFF_FFFC;
        b.rs1    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        b.rs2    = ($urandom_range(0, 3) == 0) ? b.rs1 : $urandom;
        b.imm    = $urandom;
        b.a_pc   = 1'($urandom_range(0, 1));
        b.b_imm  = 1'($urandom_range(0, 1));
        b.cmp    = 2'($urandom_range(0, 3));
        b.br     = 3'($urandom_range(0, 7));
        kind     = $urandom_range(0, 3);
        b.is_br  = (kind == 0);
        b.is_jmp = (kind == 1);
        b.rd     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        b.we     = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic drive(input bundle_t b, input logic v);
        id_valid = v; id_op = b.op; id_pc = b.pc; id_rs1 = b.rs1; id_rs2 = b.rs2;
        id_imm = b.imm; id_a_pc = b.a_pc; id_b_imm = b.b_imm; id_cmp = b.cmp;
        id_br = b.br; id_is_br = b.is_br; id_is_jmp = b.is_jmp; id_rd = b.rd; id_we = b.we;
        cur_exp = model(b);
    endtask

    // One clock: check handshake, advance the transaction model, check registered outputs.
    task automatic step();
        logic m_ready, acc;
        #1;
        m_ready = (mq.size() == 0) || ex_ready;
        check("id_ready", {31'd0, id_ready}, {31'd0, m_ready});
        acc = id_valid && m_ready && !flush;
        @(posedge clk);
        exp_redir = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && ex_ready) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(cur_exp);
                exp_redir = cur_exp.taken;
                exp_rpc   = cur_exp.target;
            end
        end
        #1;
        check("ex_valid", {31'd0, ex_valid}, {31'd0, (mq.size() != 0)});
        if (mq.size() != 0) begin
            check("ex_result", ex_result, mq[0].result);
            check("ex_rd", {27'd0, ex_rd}, {27'd0, mq[0].rd});
            check("ex_we", {31'd0, ex_we}, {31'd0, mq[0].we});
        end
        check("redirect", {31'd0, redirect}, {31'd0, exp_redir});
        if (exp_redir) check("redirect_pc", redirect_pc, exp_rpc);
    endtask

    initial begin
        bundle_t b;
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        drive(nop(), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_redir", {31'd0, redirect}, 32'd0);
        check("rst_result", ex_result, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_rd_we", {26'd0, ex_rd, ex_we}, 32'd0);
        check("rst_ready", {31'd0, id_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        b = nop(); b.rs1 = 5; b.rs2 = 7; b.rd = 3; b.we = 1;
        drive(b, 1'b1); step();
        check("add_res", ex_result, 32'd12);
        check("add_redir", {31'd0, redirect}, 32'd0);

        b = nop(); b.cmp = 2'd1; b.rs1 = 32'hFFFF_FFFF; b.rs2 = 1; b.rd = 4; b.we = 1;
        drive(b, 1'b1); step();
        check("slt_res", ex_result, 32'd1);
        b.cmp = 2'd2;
        drive(b, 1'b1); step();
        check("sltu_res", ex_result, 32'd0);

        b = nop(); b.pc = 32'h100; b.imm = 32'hFFFF_FFF8; b.rs1 = 32'hFFFF_FFFD; b.rs2 = 2;
        b.is_br = 1; b.br = 3'b100;
        drive(b, 1'b1); step();
        check("blt_redir", {31'd0, redirect}, 32'd1);
        check("blt_pc", redirect_pc, 32'hF8);
        drive(nop(), 1'b0); step();
        check("blt_pulse", {31'd0, redirect}, 32'd0);
        b.br = 3'b101;
        drive(b, 1'b1); step();
        check("bge_redir", {31'd0, redirect}, 32'd0);

        b = nop(); b.b_imm = 1; b.imm = 0; b.rs1 = 32'h203; b.pc = 32'h40;
        b.is_jmp = 1; b.rd = 1; b.we = 1;
        drive(b, 1'b1); step();
        check("jalr_res", ex_result, 32'h44);
        check("jalr_pc", redirect_pc, 32'h202);

        ex_ready = 1'b0;
        b = nop(); b.op = rvcpu::ALU_XOR; b.rs1 = 32'hF0; b.rs2 = 32'h0F; b.rd = 7; b.we = 1;
        drive(b, 1'b1);
        repeat (2) begin
            step();
            check("held_res", ex_result, 32'h44);
            check("held_ready", {31'd0, id_ready}, 32'd0);
        end
        ex_ready = 1'b1;
        step();
        check("release_res", ex_result, 32'hFF);
        b = nop(); b.op = rvcpu::ALU_SUB; b.rs1 = 10; b.rs2 = 3; b.rd = 8; b.we = 1;
        drive(b, 1'b1); step();
        check("next_res", ex_result, 32'd7);

        b = nop(); b.pc = 32'h100; b.imm = 32'hFFFF_FFF8; b.rs1 = 32'hFFFF_FFFD; b.rs2 = 2;
        b.is_br = 1; b.br = 3'b100;
        drive(b, 1'b1); flush = 1'b1; step();
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_redir", {31'd0, redirect}, 32'd0);
        flush = 1'b0;

        ex_ready = 1'b0;
        drive(rand_bundle(), 1'b1); step();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, ex_valid}, 32'd0);
        check("arst_result", ex_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        exp_redir = 1'b0;

        for (int i = 0; i < 600; i++) begin
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            drive(rand_bundle(), ($urandom_range(0, 3) != 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
